// File: rtl/data_memory_unit.sv
// data_memory_unit: doubleword data memory with a three-state IDLE/ACCESS/RESP handshake and fault detection
module data_memory_unit #(
    parameter int          DEPTH     = 32,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        ready,
    output logic        error,
    output logic        busy
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t          state;
    logic [63:0]     mem [DEPTH];
    logic [63:0]     offset;
    logic [63:0]     wdata_q;
    logic [IW-1:0]   idx_q;
    logic            write_q;
    logic            fault;
    // Full 64-bit offset so addresses past the array never alias onto low entries
    assign offset = address - BASE_ADDR;
    assign fault  = (memread & memwrite) | (|address[2:0]) | (address < BASE_ADDR) |
                    ((offset >> 3) >= 64'(DEPTH));
    assign busy   = state != IDLE;
    // Request handshake, memory access and registered response; reset clears the whole array
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            unique case (state)
                IDLE: if (memread | memwrite) begin
                    state   <= fault ? RESP : ACCESS;
                    ready   <= fault;
                    error   <= fault;
                    write_q <= memwrite;
                    idx_q   <= offset[IW+2:3];
                    wdata_q <= write_data;
                end
                ACCESS: begin
                    state <= RESP;
                    ready <= 1'b1;
                    error <= 1'b0;
                    if (write_q) mem[idx_q] <= wdata_q;
                    else read_data <= mem[idx_q];
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: scoreboard bench for data_memory_unit
module tb_data_memory_unit;
    localparam int          DEPTH = 32;
    localparam logic [63:0] BASE  = 64'h0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        memread, memwrite;
    logic [63:0] address, write_data;
    logic [63:0] read_data;
    logic        ready, error, busy;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          ready_log[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] mdl [DEPTH];
    logic [63:0] mdl_rd;

    data_memory_unit #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset_n(reset_n), .memread(memread), .memwrite(memwrite),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .error(error), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ready) ready_log.push_back(cyc);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mdl_rd = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d);
        exp_t        e;
        exp_t        got;
        logic [63:0] off;
        logic        f;
        int          lat;
        int          busy_n;
        off = a - BASE;
        f = (rd & wr) | (a[2:0] != 3'b0) | (a < BASE) | ((off >> 3) >= 64'(DEPTH));
        if (!f && wr) mdl[int'(off >> 3)] = d;
        if (!f && rd) mdl_rd = mdl[int'(off >> 3)];
        e.err = f;
        e.rdata = mdl_rd;
        e.lat = f ? 1 : 2;
        sb.push_back(e);
        @(negedge clock);
        memread = rd;
        memwrite = wr;
        address = a;
        write_data = d;
        @(posedge clock);
        #1;
        memread = 1'b0;
        memwrite = 1'b0;
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge clock);
            lat++;
            if (busy) busy_n++;
        end while (!ready && lat < 8);
        if (!ready) check("ready_timeout", 64'(ready), 64'(1));
        got = sb.pop_front();
        check("latency", 64'(lat), 64'(got.lat));
        check("error", 64'(error), 64'(got.err));
        check("read_data", read_data, got.rdata);
        check("busy_cycles", 64'(busy_n), 64'(got.lat));
        @(negedge clock);
        check("idle_after_resp", {62'b0, ready, busy}, 64'(0));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        address = '0;
        write_data = '0;
        model_reset();
        #1;
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_read_data", read_data, 64'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        issue(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
        issue(1'b1, 1'b0, 64'h10, 64'h0);
        issue(1'b1, 1'b0, 64'h0C, 64'h0);
        issue(1'b0, 1'b1, 64'h100, 64'hAAAA_BBBB_CCCC_DDDD);
        issue(1'b1, 1'b0, 64'h0, 64'h0);
        issue(1'b0, 1'b1, 64'h8, 64'h1111_1111_1111_1111);
        issue(1'b1, 1'b1, 64'h8, 64'h2222_2222_2222_2222);
        issue(1'b1, 1'b0, 64'h8, 64'h0);
        issue(1'b0, 1'b1, 64'hF8, 64'h5555_6666_7777_8888);
        issue(1'b1, 1'b0, 64'hF8, 64'h0);
        issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
        issue(1'b0, 1'b1, 64'h20, 64'h7777_7777_7777_7777);
        issue(1'b1, 1'b0, 64'h20, 64'h0);

        for (int k = 0; k < 24; k++) begin
            logic [63:0] a;
            int op;
            op = $urandom_range(0, 1);
            a = 64'($urandom_range(0, 35)) << 3;
            if ($urandom_range(0, 7) == 0) a = a + 64'h4;
            issue(op == 0, op == 1, a, {$urandom, $urandom});
        end

        @(negedge clock);
        memwrite = 1'b1;
        address = 64'h18;
        write_data = 64'h1234;
        @(posedge clock);
        #1;
        memwrite = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'(1));
        n = ready_log.size();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("abort_ready", 64'(ready), 64'(0));
        check("abort_busy_cleared", 64'(busy), 64'(0));
        check("abort_read_data", read_data, 64'(0));
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("abort_no_ready", 64'(ready_log.size()), 64'(n));
        issue(1'b1, 1'b0, 64'h18, 64'h0);
        issue(1'b1, 1'b0, 64'h10, 64'h0);

        issue(1'b0, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF);
        @(negedge clock);
        ready_log.delete();
        memread = 1'b1;
        address = 64'h0;
        repeat (12) @(negedge clock);
        memread = 1'b0;
        repeat (4) @(negedge clock);
        check("b2b_pulses", 64'(ready_log.size()), 64'(4));
        for (int i = 1; i < ready_log.size(); i++)
            check("b2b_interval", 64'(ready_log[i] - ready_log[i-1]), 64'(3));
        check("b2b_read_data", read_data, 64'h0123_4567_89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
